// File: rtl/sram_song_loader_if.sv
// Song loader bus: UART input, SRAM write port and load status.
// The loader side uses master, the consumer/bench side uses slave.
interface sram_song_loader_if #(
  parameter int ADDR_W = 18
);
  logic              uart_rx;
  logic [ADDR_W-1:0] sram_a;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic              sram_we;
  logic              sram_oe;
  logic              sram_ce;
  logic              sram_lb;
  logic              sram_ub;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
  logic              err_framing;
  logic              err_overflow;

  modport master (
    input  uart_rx,
    output sram_a, sram_dq_out, sram_dq_oe,
    output sram_we, sram_oe, sram_ce,
    output sram_lb, sram_ub,
    output load_done, word_count,
    output err_framing, err_overflow
  );

  modport slave (
    output uart_rx,
    input  sram_a, sram_dq_out, sram_dq_oe,
    input  sram_we, sram_oe, sram_ce,
    input  sram_lb, sram_ub,
    input  load_done, word_count,
    input  err_framing, err_overflow
  );
endinterface

// File: rtl/sram_song_loader.sv
// UART 8N1 receiver that packs byte pairs into 16-bit song words
// and writes them to SRAM from address 0 until an END word.
module sram_song_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 18
) (
  input logic clk,
  input logic rst,
  sram_song_loader_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } rx_t;

  typedef enum logic [2:0] {
    W_IDLE, W_SETUP, W_PULSE, W_PULSE2, W_HOLD
  } wr_t;

  rx_t rx_st, rx_nx;
  wr_t w_st, w_nx;

  logic rx_m, rx, rx_d;
  logic fall, tick_half, tick_full, last_bit;
  logic byte_vld, frame_err, word_go;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, hi_byte;
  logic hi_pend;
  logic [ADDR_W-1:0] addr;
  logic [15:0] data;
  logic [ADDR_W:0] count;
  logic done, ferr, ovf;
  logic is_end, at_top;
  logic we, dq_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx   <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= bus.uart_rx;
      rx   <= rx_m;
      rx_d <= rx;
    end
  end

  assign fall      = rx_d & ~rx;
  assign tick_half = cnt == HALF;
  assign tick_full = cnt == FULL;
  assign last_bit  = bit_cnt == 3'd7;

  always_ff @(posedge clk) begin
    if (rst) rx_st <= IDLE;
    else     rx_st <= rx_nx;
  end

  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      IDLE:  if (fall) rx_nx = START;
      START: if (tick_half) rx_nx = rx ? IDLE : DATA;
      DATA:  if (tick_full && last_bit) rx_nx = STOP;
      STOP:  if (tick_full) rx_nx = IDLE;
      default: rx_nx = IDLE;
    endcase
  end

  // Once the song is loaded the receiver keeps framing but has no effect.
  always_comb begin
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    if (rx_st == STOP && tick_full && !done) begin
      byte_vld  = rx;
      frame_err = ~rx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (rx_st != rx_nx || tick_full) cnt <= '0;
      else cnt <= cnt + CW'(1);
      if (rx_st == IDLE) begin
        bit_cnt <= '0;
      end else if (rx_st == DATA && tick_full) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {rx, shreg[7:1]};
      end
    end
  end

  assign word_go = byte_vld & hi_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_pend <= 1'b0;
      hi_byte <= '0;
      data    <= '0;
    end else if (frame_err) begin
      hi_pend <= 1'b0;
    end else if (byte_vld) begin
      if (hi_pend) begin
        data    <= {hi_byte, shreg};
        hi_pend <= 1'b0;
      end else begin
        hi_byte <= shreg;
        hi_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) w_st <= W_IDLE;
    else     w_st <= w_nx;
  end

  always_comb begin
    w_nx = w_st;
    unique case (w_st)
      W_IDLE:   if (word_go) w_nx = W_SETUP;
      W_SETUP:  w_nx = W_PULSE;
      W_PULSE:  w_nx = W_PULSE2;
      W_PULSE2: w_nx = W_HOLD;
      W_HOLD:   w_nx = W_IDLE;
      default:  w_nx = W_IDLE;
    endcase
  end

  always_comb begin
    we    = 1'b1;
    dq_oe = 1'b0;
    unique case (w_st)
      W_SETUP, W_HOLD: dq_oe = 1'b1;
      W_PULSE, W_PULSE2: begin
        we    = 1'b0;
        dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_end = data[15:12] == 4'b0000;
  assign at_top = &addr;

  // The top address never wraps; it is the final slot either way.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      count <= '0;
      done  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (frame_err) ferr <= 1'b1;
      if (w_st == W_HOLD) begin
        count <= count + (ADDR_W + 1)'(1);
        if (!at_top) addr <= addr + ADDR_W'(1);
        if (is_end) begin
          done <= 1'b1;
        end else if (at_top) begin
          done <= 1'b1;
          ovf  <= 1'b1;
        end
      end
    end
  end

  assign bus.sram_a       = addr;
  assign bus.sram_dq_out  = data;
  assign bus.sram_dq_oe   = dq_oe;
  assign bus.sram_we      = we;
  assign bus.sram_oe      = 1'b1;
  assign bus.sram_ce      = 1'b0;
  assign bus.sram_lb      = 1'b0;
  assign bus.sram_ub      = 1'b0;
  assign bus.load_done    = done;
  assign bus.word_count   = count;
  assign bus.err_framing  = ferr;
  assign bus.err_overflow = ovf;
endmodule

// File: tb/tb_sram_song_loader.sv
// Bench for sram_song_loader: directed and random songs over UART,
// a behavioural SRAM and a byte-stream reference model.
module tb_sram_song_loader;
  localparam int CPB   = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  sram_song_loader_if #(.ADDR_W(AW)) bus ();

  sram_song_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [DEPTH];
  int we_cyc = 0;
  int low_len = 0;
  int pulse_bad = 0;
  int stab_bad = 0;
  int last_wr_a = -1;
  bit ignore_pulse = 1'b0;
  logic prev_oe = 1'b0;
  logic [AW-1:0] prev_a = '0;
  logic [15:0] prev_dq = '0;

  always @(negedge clk) begin
    if (bus.sram_we === 1'b0) begin
      mem[bus.sram_a] = bus.sram_dq_out;
      we_cyc++;
      low_len++;
      last_wr_a = int'(bus.sram_a);
    end else begin
      if (low_len != 0 && low_len != 2 && !ignore_pulse)
        pulse_bad++;
      low_len = 0;
    end
    if (bus.sram_dq_oe && prev_oe &&
        (bus.sram_a !== prev_a || bus.sram_dq_out !== prev_dq))
      stab_bad++;
    prev_oe = bus.sram_dq_oe;
    prev_a  = bus.sram_a;
    prev_dq = bus.sram_dq_out;
  end

  logic [7:0] bq [$];
  bit sq [$];
  logic [15:0] exp_mem [DEPTH];
  int exp_wc;
  bit exp_done, exp_ovf, exp_ferr;

  // Reference: walk the byte stream, pair bytes, stop at END or full.
  task automatic model();
    bit have;
    logic [7:0] hi;
    logic [15:0] w;
    have = 0;
    hi = '0;
    exp_wc = 0;
    exp_done = 0;
    exp_ovf = 0;
    exp_ferr = 0;
    foreach (exp_mem[i]) exp_mem[i] = 16'hdead;
    foreach (bq[i]) begin
      if (exp_done) continue;
      if (!sq[i]) begin
        exp_ferr = 1;
        have = 0;
        continue;
      end
      if (!have) begin
        hi = bq[i];
        have = 1;
        continue;
      end
      have = 0;
      w = {hi, bq[i]};
      exp_mem[exp_wc] = w;
      exp_wc++;
      if (w[15:12] == 4'h0) begin
        exp_done = 1;
      end else if (exp_wc == DEPTH) begin
        exp_done = 1;
        exp_ovf = 1;
      end
    end
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    bus.uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic tx(input logic [7:0] b, input bit ok);
    bq.push_back(b);
    sq.push_back(ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(ok);
    bit_time(1'b1);
    bit_time(1'b1);
  endtask

  task automatic do_reset();
    bus.uart_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    foreach (mem[i]) mem[i] = 16'hdead;
    we_cyc = 0;
    pulse_bad = 0;
    stab_bad = 0;
    low_len = 0;
    last_wr_a = -1;
    bq.delete();
    sq.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_song(input string t);
    int ea;
    repeat (20) @(negedge clk);
    model();
    ea = (exp_wc == DEPTH) ? DEPTH - 1 : exp_wc;
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s mem%0d", t, i), mem[i], exp_mem[i]);
    check({t, " wc"}, 32'(bus.word_count), exp_wc);
    check({t, " done"}, 32'(bus.load_done), 32'(exp_done));
    check({t, " ovf"}, 32'(bus.err_overflow), 32'(exp_ovf));
    check({t, " ferr"}, 32'(bus.err_framing), 32'(exp_ferr));
    check({t, " addr"}, 32'(bus.sram_a), ea);
    check({t, " we_cyc"}, we_cyc, 2 * exp_wc);
    check({t, " pulse"}, pulse_bad, 0);
    check({t, " stable"}, stab_bad, 0);
    check({t, " we_idle"}, 32'(bus.sram_we), 1);
  endtask

  initial begin
    bit hit;
    int n;
    logic [7:0] b;
    bit ok;
    bus.uart_rx = 1'b1;

    do_reset();
    check("rst a", 32'(bus.sram_a), 0);
    check("rst dq", 32'(bus.sram_dq_out), 0);
    check("rst dq_oe", 32'(bus.sram_dq_oe), 0);
    check("rst we", 32'(bus.sram_we), 1);
    check("rst oe", 32'(bus.sram_oe), 1);
    check("rst ce", 32'(bus.sram_ce), 0);
    check("rst done", 32'(bus.load_done), 0);
    check("rst wc", 32'(bus.word_count), 0);
    check("rst ferr", 32'(bus.err_framing), 0);
    check("rst ovf", 32'(bus.err_overflow), 0);

    tx(8'h10, 1); tx(8'h60, 1); tx(8'h00, 1); tx(8'h00, 1);
    check_song("t1");
    check("t1 word0", 32'(mem[0]), 32'h1060);

    tx(8'h90, 1); tx(8'h01, 1);
    check_song("t4");

    do_reset();
    tx(8'h81, 0); tx(8'h81, 1); tx(8'h23, 1);
    tx(8'h00, 1); tx(8'h00, 1);
    check_song("t2");
    check("t2 word0", 32'(mem[0]), 32'h8123);

    do_reset();
    bus.uart_rx = 1'b0;
    @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    check("t3 we_cyc", we_cyc, 0);
    check("t3 wc", 32'(bus.word_count), 0);

    do_reset();
    ignore_pulse = 1'b1;
    hit = 0;
    fork
      begin
        tx(8'h12, 1); tx(8'h34, 1); tx(8'h56, 1); tx(8'h78, 1);
      end
      begin
        for (int i = 0; i < 2000 && !hit; i++) begin
          @(negedge clk);
          if (bus.word_count == 1 && bus.sram_we === 1'b0) hit = 1;
        end
        if (hit) begin
          check("t5 pre_a", 32'(bus.sram_a), 1);
          rst = 1'b1;
          @(negedge clk);
          check("t5 we", 32'(bus.sram_we), 1);
          check("t5 a", 32'(bus.sram_a), 0);
          check("t5 wc", 32'(bus.word_count), 0);
          check("t5 dq_oe", 32'(bus.sram_dq_oe), 0);
          check("t5 done", 32'(bus.load_done), 0);
          rst = 1'b0;
        end else begin
          check("t5 pulse_seen", 0, 1);
        end
      end
    join
    do_reset();
    ignore_pulse = 1'b0;

    for (int k = 0; k < 8; k++) begin
      tx(8'h80, 1);
      tx(8'h01, 1);
    end
    check_song("t6");
    check("t6 last_wr", last_wr_a, DEPTH - 1);

    for (int s = 0; s < 12; s++) begin
      do_reset();
      n = $urandom_range(2, 22);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 4) == 0) b[7:4] = 4'h0;
        ok = $urandom_range(0, 11) != 0;
        tx(b, ok);
      end
      check_song($sformatf("rnd%0d", s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
